// File: rtl/mac_kbd_xact.sv
// mac_kbd_xact: Mac keyboard transactor with a DEPTH-entry key FIFO.
// Answers Inquiry/Instant/Model/Test commands with paced, registered replies.
// Optional Caps Lock latching is compiled in with MAC_KBD_CAPS_LOCK_EN.
module mac_kbd_xact #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMER_W     = 20,
  parameter int unsigned SHORT_TICKS = 4095,
  parameter int unsigned LONG_TICKS  = 1048575,
  parameter logic [7:0]  MODEL_ID    = 8'h03,
  parameter logic [7:0]  TEST_ACK    = 8'h7d
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic                     key_stb,
  input  logic                     key_press,
  input  logic [8:0]               key_code,
  input  logic                     key_is_caps,
  output logic                     capslock,
  input  logic [7:0]               data_out,
  input  logic                     strobe_out,
  output logic [7:0]               data_in,
  output logic                     strobe_in,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [TIMER_W-1:0] SHORT_T = TIMER_W'(SHORT_TICKS);
  localparam logic [TIMER_W-1:0] LONG_T  = TIMER_W'(LONG_TICKS);

  localparam logic [7:0] CMD_INQUIRY = 8'h10;
  localparam logic [7:0] CMD_INSTANT = 8'h14;
  localparam logic [7:0] CMD_MODEL   = 8'h16;
  localparam logic [7:0] CMD_TEST    = 8'h36;
  localparam logic [7:0] NULL_REPLY  = 8'h7b;
  localparam logic [7:0] KEYPAD_PFX  = 8'h79;

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               inq_q, inq_d;
  logic               inst_q, inst_d;
  logic               model_q, model_d;
  logic               test_q, test_d;
  logic               inq_act_q, inq_act_d;
  logic [8:0]         mem_q [DEPTH];
  logic [8:0]         mem_d [DEPTH];
  logic [PW-1:0]      rd_q, rd_d;
  logic [PW-1:0]      wr_q, wr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               caps_q, caps_d;
  logic [7:0]         data_in_q, data_in_d;
  logic               strobe_in_q, strobe_in_d;

  logic               tick_short, tick_long, have_head;
  logic               flush, pop, head_rep, reply, caps_drop, push_ok;
  logic [7:0]         reply_byte;
  logic [8:0]         head, entry;
  logic [LW-1:0]      lvl_base;
  logic [PW-1:0]      wr_base;
  logic               unused_ok;

  assign unused_ok  = ^{key_code[7], key_is_caps};
  assign tick_short = (timer_q == SHORT_T);
  assign tick_long  = (timer_q == LONG_T);
  assign have_head  = (level_q != '0);
  assign head       = mem_q[rd_q];
  assign entry      = {key_code[8], ~key_press, key_code[6:0]};

  assign capslock   = caps_q;
  assign data_in    = data_in_q;
  assign strobe_in  = strobe_in_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

  // Next-state: command latch, pacing timer, reply decision and FIFO update.
  always_comb begin
    timer_d     = timer_q;
    inq_d       = inq_q;
    inst_d      = inst_q;
    model_d     = model_q;
    test_d      = test_q;
    inq_act_d   = inq_act_q;
    mem_d       = mem_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    level_d     = level_q;
    ovf_d       = ovf_q;
    caps_d      = caps_q;
    data_in_d   = data_in_q;
    strobe_in_d = 1'b0;
    flush       = 1'b0;
    pop         = 1'b0;
    head_rep    = 1'b0;
    reply       = 1'b0;
    reply_byte  = NULL_REPLY;
    caps_drop   = 1'b0;
    push_ok     = 1'b0;
    lvl_base    = level_q;
    wr_base     = wr_q;

    if (ce) begin
`ifdef MAC_KBD_CAPS_LOCK_EN
      // Only the press that turns the latch on and the release while off reach the Mac.
      if (key_stb && key_is_caps) begin
        caps_drop = caps_q;
        if (key_press) begin
          caps_d = ~caps_q;
        end
      end
`else
      caps_d = 1'b0;
`endif

      if (strobe_out) begin
        timer_d   = '0;
        inq_d     = (data_out == CMD_INQUIRY);
        inst_d    = (data_out == CMD_INSTANT);
        model_d   = (data_out == CMD_MODEL);
        test_d    = (data_out == CMD_TEST);
        inq_act_d = 1'b0;
        flush     = (data_out == CMD_MODEL) || (data_out == CMD_TEST);
        if (data_out == CMD_TEST) begin
          ovf_d = 1'b0;
        end
      end else begin
        if (timer_q != LONG_T) begin
          timer_d = timer_q + TIMER_W'(1);
        end
        if (model_q && tick_short) begin
          reply      = 1'b1;
          reply_byte = MODEL_ID;
          model_d    = 1'b0;
        end else if (test_q && tick_short) begin
          reply      = 1'b1;
          reply_byte = TEST_ACK;
          test_d     = 1'b0;
        end else if (inst_q && tick_short) begin
          inst_d = 1'b0;
          if (have_head) begin
            head_rep = 1'b1;
          end else begin
            reply = 1'b1;
          end
        end else if (inq_act_q) begin
          if (have_head) begin
            head_rep  = 1'b1;
            inq_d     = 1'b0;
            inq_act_d = 1'b0;
          end else if (tick_long) begin
            reply     = 1'b1;
            inq_d     = 1'b0;
            inq_act_d = 1'b0;
          end
        end else if (inq_q && tick_short) begin
          inq_act_d = 1'b1;
        end
      end

      // Keypad entries go out as a prefix first; the code byte stays queued.
      if (head_rep) begin
        reply = 1'b1;
        if (head[8]) begin
          reply_byte      = KEYPAD_PFX;
          mem_d[rd_q][8]  = 1'b0;
        end else begin
          reply_byte = head[7:0];
          pop        = 1'b1;
        end
      end

      if (flush) begin
        lvl_base = '0;
        wr_base  = '0;
        rd_d     = '0;
      end else if (pop) begin
        rd_d = rd_q + PW'(1);
      end

      if (key_stb && !caps_drop) begin
        if ((lvl_base < LW'(DEPTH)) || pop) begin
          mem_d[wr_base] = entry;
          push_ok        = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      wr_d    = push_ok ? (wr_base + PW'(1)) : wr_base;
      level_d = lvl_base + LW'(push_ok) - LW'(pop);

      if (reply) begin
        data_in_d   = reply_byte;
        strobe_in_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q     <= '0;
      inq_q       <= 1'b0;
      inst_q      <= 1'b0;
      model_q     <= 1'b0;
      test_q      <= 1'b0;
      inq_act_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_q        <= '0;
      wr_q        <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      caps_q      <= 1'b0;
      data_in_q   <= NULL_REPLY;
      strobe_in_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      inq_q       <= inq_d;
      inst_q      <= inst_d;
      model_q     <= model_d;
      test_q      <= test_d;
      inq_act_q   <= inq_act_d;
      mem_q       <= mem_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      caps_q      <= caps_d;
      data_in_q   <= data_in_d;
      strobe_in_q <= strobe_in_d;
    end
  end

endmodule

// File: tb/tb_mac_kbd_xact.sv
// tb_mac_kbd_xact: table vectors, hand sequences and random traffic against a queue model.
module tb_mac_kbd_xact;

  localparam int DEPTH = 8;
  localparam int SHORT = 20;
  localparam int LONG  = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       key_stb;
  logic       key_press;
  logic [8:0] key_code;
  logic       key_is_caps;
  logic       capslock;
  logic [7:0] data_out;
  logic       strobe_out;
  logic [7:0] data_in;
  logic       strobe_in;
  logic [3:0] fifo_level;
  logic       overflow;

  mac_kbd_xact #(
    .DEPTH(DEPTH), .TIMER_W(8), .SHORT_TICKS(SHORT), .LONG_TICKS(LONG),
    .MODEL_ID(8'h03), .TEST_ACK(8'h7d)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .key_stb(key_stb), .key_press(key_press),
    .key_code(key_code), .key_is_caps(key_is_caps), .capslock(capslock),
    .data_out(data_out), .strobe_out(strobe_out), .data_in(data_in),
    .strobe_in(strobe_in), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: queue of {keypad, ~press, code} entries.
  logic [8:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_caps = 1'b0;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", nm, idx, act, exp);
  endtask

  task automatic push_key(input logic [8:0] code, input logic press, input logic caps);
    bit drop;
    drop = 1'b0;
    @(negedge clk);
    key_stb = 1'b1; key_code = code; key_press = press; key_is_caps = caps;
    @(negedge clk);
    key_stb = 1'b0; key_is_caps = 1'b0;
`ifdef MAC_KBD_CAPS_LOCK_EN
    if (caps) begin
      drop = m_caps;
      if (press) m_caps = ~m_caps;
    end
`endif
    if (!drop) begin
      if (q.size() < DEPTH) q.push_back({code[8], ~press, code[6:0]});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_head(output logic [7:0] b);
    logic [8:0] e;
    e = q[0];
    if (e[8]) begin
      b = 8'h79;
      e[8] = 1'b0;
      q[0] = e;
    end else begin
      e = q.pop_front();
      b = e[7:0];
    end
  endtask

  // Expected reply byte and latency (clk edges after the command edge); lat 0 = no reply.
  task automatic model_cmd(input logic [7:0] cmd, output int lat, output logic [7:0] b);
    lat = 0; b = 8'h00;
    case (cmd)
      8'h16: begin lat = SHORT + 1; b = 8'h03; q.delete(); end
      8'h36: begin lat = SHORT + 1; b = 8'h7d; q.delete(); m_ovf = 1'b0; end
      8'h14: begin
        lat = SHORT + 1;
        if (q.size() == 0) b = 8'h7b; else model_head(b);
      end
      8'h10: begin
        if (q.size() == 0) begin lat = LONG + 1; b = 8'h7b; end
        else begin lat = SHORT + 2; model_head(b); end
      end
      default: ;
    endcase
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    @(negedge clk);
    strobe_out = 1'b1; data_out = cmd;
    @(negedge clk);
    strobe_out = 1'b0;
  endtask

  task automatic wait_reply(output int lat, output logic [7:0] d, output bit pulse_ok);
    lat = 0; d = 8'h00; pulse_ok = 1'b1;
    for (int n = 1; n <= LONG + 20; n++) begin
      @(negedge clk);
      if (strobe_in) begin
        lat = n; d = data_in;
        @(negedge clk);
        pulse_ok = !strobe_in;
        break;
      end
    end
  endtask

  task automatic do_cmd(input logic [7:0] cmd, output int lat, output logic [7:0] d, output bit pulse_ok);
    send_cmd(cmd);
    wait_reply(lat, d, pulse_ok);
  endtask

  typedef struct {
    logic [8:0] key;
    logic       press;
    int         nkeys;
    logic [7:0] cmd;
    logic [7:0] exp_b;
    int         exp_lat;
    int         exp_lvl;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int         lat, mlat, n;
    logic [7:0] d, mb, cmd;
    bit         pok;
    logic [8:0] code;
    logic [7:0] cmds[7];

    reset = 1'b1; ce = 1'b1; key_stb = 1'b0; key_press = 1'b0; key_code = '0;
    key_is_caps = 1'b0; data_out = '0; strobe_out = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_data", 0, data_in, 8'h7b);
    chk("rst_strobe", 0, strobe_in, 0);
    chk("rst_level", 0, fifo_level, 0);
    chk("rst_ovf", 0, overflow, 0);
    chk("rst_caps", 0, capslock, 0);

    tbl[0]  = '{9'h000, 1'b0, 0, 8'h16, 8'h03, SHORT + 1, 0};
    tbl[1]  = '{9'h127, 1'b1, 1, 8'h10, 8'h79, SHORT + 2, 1};
    tbl[2]  = '{9'h000, 1'b0, 0, 8'h10, 8'h27, SHORT + 2, 0};
    tbl[3]  = '{9'h000, 1'b0, 0, 8'h10, 8'h7b, LONG + 1,  0};
    tbl[4]  = '{9'h001, 1'b0, 1, 8'h14, 8'h81, SHORT + 1, 0};
    tbl[5]  = '{9'h000, 1'b0, 0, 8'h14, 8'h7b, SHORT + 1, 0};
    tbl[6]  = '{9'h0A5, 1'b1, 1, 8'h14, 8'h25, SHORT + 1, 0};
    tbl[7]  = '{9'h142, 1'b0, 1, 8'h14, 8'h79, SHORT + 1, 1};
    tbl[8]  = '{9'h000, 1'b0, 0, 8'h14, 8'hC2, SHORT + 1, 0};
    tbl[9]  = '{9'h033, 1'b1, 2, 8'h36, 8'h7d, SHORT + 1, 0};
    tbl[10] = '{9'h011, 1'b1, 1, 8'h55, 8'h00, 0,         1};
    tbl[11] = '{9'h000, 1'b0, 0, 8'h14, 8'h11, SHORT + 1, 0};

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].nkeys; k++) push_key(tbl[i].key, tbl[i].press, 1'b0);
      model_cmd(tbl[i].cmd, mlat, mb);
      do_cmd(tbl[i].cmd, lat, d, pok);
      chk("tbl_lat", i, lat, tbl[i].exp_lat);
      if (tbl[i].exp_lat != 0) begin
        chk("tbl_data", i, d, tbl[i].exp_b);
        chk("tbl_pulse", i, pok, 1);
      end
      chk("tbl_level", i, fifo_level, tbl[i].exp_lvl);
    end

    // Overflow: nine pushes into an eight-entry FIFO, then Test clears it.
    for (int i = 0; i < 9; i++) push_key(9'h010 + 9'(i), 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_level", 0, fifo_level, 8);
    chk("ovf_flag", 0, overflow, 1);
    model_cmd(8'h36, mlat, mb);
    do_cmd(8'h36, lat, d, pok);
    chk("test_data", 0, d, 8'h7d);
    chk("test_lat", 0, lat, SHORT + 1);
    chk("test_ovf", 0, overflow, 0);
    chk("test_level", 0, fifo_level, 0);

    // Inquiry goes active on an empty FIFO; a later key is answered within 2 clk.
    send_cmd(8'h10);
    n = 0;
    repeat (SHORT + 5) begin @(negedge clk); if (strobe_in) n++; end
    chk("inq_idle_strobes", 0, n, 0);
    push_key(9'h001, 1'b0, 1'b0);
    lat = 0;
    for (int k = 1; k <= 2; k++) begin
      if (strobe_in) begin lat = k; d = data_in; break; end
      @(negedge clk);
    end
    chk("inq_key_seen", 0, (lat != 0), 1);
    chk("inq_key_data", 0, d, 8'h81);
    @(negedge clk);
    chk("inq_key_level", 0, fifo_level, 0);
    void'(q.pop_front());

    // Gated clock enable stretches the pacing by the gated cycles.
    model_cmd(8'h16, mlat, mb);
    send_cmd(8'h16);
    fork
      begin
        repeat (3) @(negedge clk);
        ce = 1'b0;
        repeat (10) @(negedge clk);
        ce = 1'b1;
      end
    join_none
    wait_reply(lat, d, pok);
    chk("ce_lat", 0, lat, SHORT + 11);
    chk("ce_data", 0, d, 8'h03);

    // Async reset during a pending Model reply: everything clears, no reply follows.
    send_cmd(8'h16);
    push_key(9'h044, 1'b1, 1'b0);
    chk("pend_level", 0, fifo_level, 1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_level", 0, fifo_level, 0);
    chk("midrst_data", 0, data_in, 8'h7b);
    reset = 1'b0;
    q.delete(); m_ovf = 1'b0; m_caps = 1'b0;
    n = 0;
    repeat (SHORT + 20) begin @(negedge clk); if (strobe_in) n++; end
    chk("midrst_strobes", 0, n, 0);

`ifdef MAC_KBD_CAPS_LOCK_EN
    push_key(9'h073, 1'b1, 1'b1); chk("caps_on", 0, capslock, 1);
    push_key(9'h073, 1'b0, 1'b1); chk("caps_on", 1, capslock, 1);
    push_key(9'h073, 1'b1, 1'b1); chk("caps_off", 0, capslock, 0);
    push_key(9'h073, 1'b0, 1'b1); chk("caps_off", 1, capslock, 0);
    chk("caps_level", 0, fifo_level, 2);
    model_cmd(8'h14, mlat, mb);
    do_cmd(8'h14, lat, d, pok); chk("caps_q0", 0, d, 8'h73);
    model_cmd(8'h14, mlat, mb);
    do_cmd(8'h14, lat, d, pok); chk("caps_q1", 0, d, 8'hF3);
`endif

    // Random traffic against the queue model.
    cmds[0] = 8'h14; cmds[1] = 8'h10; cmds[2] = 8'h10; cmds[3] = 8'h16;
    cmds[4] = 8'h36; cmds[5] = 8'h14; cmds[6] = 8'h55;
    for (int it = 0; it < 40; it++) begin
      n = int'($urandom_range(0, 4));
      for (int k = 0; k < n; k++) begin
        code = 9'($urandom);
        code[8] = ($urandom_range(0, 3) == 0);
        push_key(code, 1'($urandom), 1'b0);
      end
      cmd = cmds[$urandom_range(0, 6)];
      model_cmd(cmd, mlat, mb);
      do_cmd(cmd, lat, d, pok);
      chk("rnd_lat", it, lat, mlat);
      if (mlat != 0) begin
        chk("rnd_data", it, d, mb);
        chk("rnd_pulse", it, pok, 1);
      end
      chk("rnd_level", it, fifo_level, q.size());
      chk("rnd_ovf", it, overflow, m_ovf);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
